// File: rtl/wb_interconnect_arb_pkg.sv
// Shared definitions for the Wishbone request arbiter.
//   arb_state_e : arbiter FSM states (IDLE = no grant, BUSY = grant held)
//   MODE_FIXED  : fixed priority, lowest index wins
//   MODE_RR     : round robin, search starts after the last granted index
//   id_width()  : width of a binary requester index (never below 1)
package wb_interconnect_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_interconnect_arb_sel.sv
// Combinational rotating-priority picker.
//   req_i   : request vector
//   mask_i  : requesters excluded from this pick (bit set = excluded)
//   start_i : index searched first; the search walks upward and wraps to 0
//   idx_o   : index of the first unmasked requester found
//   found_o : high when any unmasked requester exists
module wb_interconnect_arb_sel #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] mask_i,
  input  logic [ID_W-1:0]  start_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             found_o
);

  logic [N_REQ-1:0] cand;
  int               pos;
  logic [ID_W-1:0]  pos_id;

  assign cand = req_i & ~mask_i;

  // NOTE: every output and temporary gets a default at the top of the block,
  // so no path through the loop leaves a value unassigned (no latch).
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_id  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos = int'(start_i) + i;
      if (pos >= N_REQ) pos = pos - N_REQ;
      pos_id = ID_W'(pos);
      if (!found_o && cand[pos_id]) begin
        found_o = 1'b1;
        idx_o   = pos_id;
      end
    end
  end

endmodule

// File: rtl/wb_interconnect_arb_rr.sv
// N-way bus arbiter with fixed-priority or round-robin policy and an
// optional hold limit that forcibly hands the bus on when others wait.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   req       : per-requester request / hold
//   gnt       : registered one-hot (or zero) grant
//   gnt_id    : binary index of the granted requester (valid with gnt_valid)
//   gnt_valid : any grant active
//   preempt   : one-cycle pulse on the first cycle after a forced revoke
module wb_interconnect_arb_rr
  import wb_interconnect_arb_pkg::*;
#(
  parameter int  N_REQ    = 4,
  parameter int  MODE     = MODE_RR,
  parameter int  HOLD_MAX = 0,
  localparam int ID_W     = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam int              CNT_W    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LIM  = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);

  arb_state_e       state_q;
  logic [N_REQ-1:0] gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic             gnt_valid_q;
  logic             preempt_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [ID_W-1:0]  last_id_q;

  logic             holder_req;
  logic             others_req;
  logic             limit_hit;
  logic [N_REQ-1:0] sel_mask;
  logic [ID_W-1:0]  sel_start;
  logic [ID_W-1:0]  win_id;
  logic             win_found;

  // gnt_q is one-hot, so this is req[gnt_id] without an index select.
  assign holder_req = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);

  always_comb begin
    limit_hit = 1'b0;
    sel_mask  = '0;
    sel_start = '0;
    // >= rather than == so a saturated counter still triggers once a
    // competitor shows up later.
    if ((HOLD_MAX > 0) && (state_q == ST_BUSY) && holder_req && others_req &&
        (hold_cnt_q >= CNT_LIM)) begin
      limit_hit = 1'b1;
    end
    // On a forced handover the current holder must not win again.
    if (limit_hit) sel_mask = gnt_q;
    if (MODE == MODE_RR) begin
      sel_start = (last_id_q == LAST_RST) ? '0 : last_id_q + ID_W'(1);
    end
  end

  wb_interconnect_arb_sel #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_sel (
    .req_i   (req),
    .mask_i  (sel_mask),
    .start_i (sel_start),
    .idx_o   (win_id),
    .found_o (win_found)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      hold_cnt_q  <= '0;
      last_id_q   <= LAST_RST;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            state_q     <= ST_BUSY;
            gnt_q       <= N_REQ'(1) << win_id;
            gnt_id_q    <= win_id;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= '0;
            last_id_q   <= win_id;
          end
        end
        ST_BUSY: begin
          if (holder_req && !limit_hit) begin
            if (hold_cnt_q != CNT_TOP) hold_cnt_q <= hold_cnt_q + 1'b1;
          end else if (win_found) begin
            // Release or forced handover: next winner with no idle gap.
            gnt_q       <= N_REQ'(1) << win_id;
            gnt_id_q    <= win_id;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= '0;
            last_id_q   <= win_id;
            preempt_q   <= limit_hit;
          end else begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;

endmodule

// File: tb/tb_wb_interconnect_arb_rr.sv
// Directed and random checks of wb_interconnect_arb_rr with N_REQ = 4 in
// three configurations: round robin, fixed priority, round robin + HOLD_MAX=3.
module tb_wb_interconnect_arb_rr;

  logic       clk;
  logic       rst;
  logic [3:0] req_rr, req_fx, req_hm;
  logic [3:0] gnt_rr, gnt_fx, gnt_hm;
  logic [1:0] id_rr, id_fx, id_hm;
  logic       val_rr, val_fx, val_hm;
  logic       pre_rr, pre_fx, pre_hm;

  int total = 0;
  int bad   = 0;

  wb_interconnect_arb_rr #(.N_REQ(4), .MODE(1), .HOLD_MAX(0)) u_rr (
    .clk(clk), .rst(rst), .req(req_rr), .gnt(gnt_rr),
    .gnt_id(id_rr), .gnt_valid(val_rr), .preempt(pre_rr)
  );

  wb_interconnect_arb_rr #(.N_REQ(4), .MODE(0), .HOLD_MAX(0)) u_fx (
    .clk(clk), .rst(rst), .req(req_fx), .gnt(gnt_fx),
    .gnt_id(id_fx), .gnt_valid(val_fx), .preempt(pre_fx)
  );

  wb_interconnect_arb_rr #(.N_REQ(4), .MODE(1), .HOLD_MAX(3)) u_hm (
    .clk(clk), .rst(rst), .req(req_hm), .gnt(gnt_hm),
    .gnt_id(id_hm), .gnt_valid(val_hm), .preempt(pre_hm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic inv_ok(input logic [3:0] g, input logic [1:0] id, input logic v);
    logic [3:0] one;
    one = 4'b0001 << id;
    return $onehot0(g) && (v === (|g)) && (!v || (g === one));
  endfunction

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    check("inv_rr", 32'(inv_ok(gnt_rr, id_rr, val_rr)), 32'd1);
    check("inv_fx", 32'(inv_ok(gnt_fx, id_fx, val_fx)), 32'd1);
    check("inv_hm", 32'(inv_ok(gnt_hm, id_hm, val_hm)), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [3:0] hm_g [7];
    logic       hm_p [7];
    logic [3:0] prev_g;
    int         wait_cnt [4];
    int         max_wait;
    logic       new_g;

    rst = 1'b0;
    req_rr = '0; req_fx = '0; req_hm = '0;
    #1;
    check("rst_gnt",     32'(gnt_rr), 32'h0);
    check("rst_valid",   32'(val_rr), 32'h0);
    check("rst_id",      32'(id_rr),  32'h0);
    check("rst_preempt", 32'(pre_hm), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("idle_no_req", 32'(gnt_rr), 32'h0);

    // Fixed priority: lowest index, holder kept, non-granted toggles ignored.
    req_fx = 4'b1010; tick();
    check("fx_first",      32'(gnt_fx), 32'h2);
    check("fx_first_id",   32'(id_fx),  32'h1);
    req_fx = 4'b0010; tick();
    check("fx_other_drop", 32'(gnt_fx), 32'h2);
    req_fx = 4'b1010; tick();
    check("fx_other_back", 32'(gnt_fx), 32'h2);
    req_fx = 4'b1000; tick();
    check("fx_release",    32'(gnt_fx), 32'h8);
    check("fx_release_id", 32'(id_fx),  32'h3);
    req_fx = 4'b1001; tick();
    check("fx_hold_vs_low", 32'(gnt_fx), 32'h8);
    req_fx = 4'b0001; tick();
    check("fx_next",       32'(gnt_fx), 32'h1);
    req_fx = 4'b0000; tick();
    check("fx_idle",       32'(gnt_fx), 32'h0);
    check("fx_idle_valid", 32'(val_fx), 32'h0);

    // Round robin rotation 0,1,2,3,0 with each holder dropping once.
    req_rr = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_g = 4'b0001 << k;
      check("rr_hold", 32'(gnt_rr), 32'(exp_g));
      req_rr = 4'b1111 & ~exp_g;
      tick();
      exp_g = 4'b0001 << ((k + 1) % 4);
      check("rr_next", 32'(gnt_rr), 32'(exp_g));
      req_rr = 4'b1111;
    end
    req_rr = 4'b0000; tick();
    check("rr_idle", 32'(gnt_rr), 32'h0);
    // last_id is 0: sole requester 0 wraps round to itself.
    req_rr = 4'b0001; tick();
    check("rr_self_regrant", 32'(gnt_rr), 32'h1);
    req_rr = 4'b0000; tick();
    // Search starts at 1, so 3 beats 0.
    req_rr = 4'b1001; tick();
    check("rr_pointer", 32'(gnt_rr), 32'h8);
    req_rr = 4'b0000; tick();

    // Asynchronous reset in the middle of a grant.
    req_rr = 4'b0100; tick();
    check("rr_pre_reset", 32'(gnt_rr), 32'h4);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_gnt",   32'(gnt_rr), 32'h0);
    check("async_rst_valid", 32'(val_rr), 32'h0);
    req_rr = 4'b0000;
    tick();
    rst = 1'b1;
    req_rr = 4'b0110; tick();
    check("post_rst_gnt", 32'(gnt_rr), 32'h2);
    check("post_rst_id",  32'(id_rr),  32'h1);
    req_rr = 4'b0000; tick();

    // Hold limit 3 with two competitors.
    hm_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    hm_p = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    req_hm = 4'b0011;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("hm_gnt",     32'(gnt_hm), 32'(hm_g[k]));
      check("hm_preempt", 32'(pre_hm), 32'(hm_p[k]));
    end
    req_hm = 4'b0000; tick();
    check("hm_idle", 32'(gnt_hm), 32'h0);

    // Sole holder past the limit keeps the bus; a late competitor preempts.
    req_hm = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("hm_sole_gnt",     32'(gnt_hm), 32'h1);
      check("hm_sole_preempt", 32'(pre_hm), 32'h0);
    end
    req_hm = 4'b0011; tick();
    check("hm_late_gnt",     32'(gnt_hm), 32'h2);
    check("hm_late_preempt", 32'(pre_hm), 32'h1);
    req_hm = 4'b0000; tick();
    check("hm_late_pulse",   32'(pre_hm), 32'h0);

    // Random traffic on all three; round-robin starvation bound on u_rr.
    for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    max_wait = 0;
    prev_g   = gnt_rr;
    for (int c = 0; c < 10000; c++) begin
      req_rr = 4'($urandom());
      req_fx = 4'($urandom());
      req_hm = 4'($urandom());
      tick();
      new_g = (gnt_rr != prev_g) && (gnt_rr != 4'b0000);
      for (int i = 0; i < 4; i++) begin
        if (!req_rr[i] || gnt_rr[i]) wait_cnt[i] = 0;
        else if (new_g) wait_cnt[i] = wait_cnt[i] + 1;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      prev_g = gnt_rr;
    end
    check("rr_fairness", 32'(max_wait <= 4), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_interconnect_arb_rr.md
WB_INTERCONNECT_ARB_RR -- requirements
Module: wb_interconnect_arb_rr

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; legal range 2..32.
REQ-002 Parameter MODE, default 1, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-003 Parameter HOLD_MAX, default 0, maximum cycles one grant is held while others wait; 0 = unlimited.
REQ-004 clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester request; bit i high = master i wants, or holds, the bus.
REQ-007 gnt  output  N_REQ  one-hot (or zero) registered grant.
REQ-008 gnt_id  output  max(1,$clog2(N_REQ))  binary index of the granted requester; valid when gnt_valid = 1.
REQ-009 gnt_valid  output  1  high when any gnt bit is high.
REQ-010 preempt  output  1  one-cycle pulse coincident with the first cycle a grant is forcibly revoked by HOLD_MAX.

Function
REQ-011 gnt SHALL have at most one bit set in every cycle; gnt_valid SHALL equal the OR of gnt; gnt_id SHALL encode gnt.
REQ-012 FSM SHALL have states IDLE (no grant) and BUSY (grant held).
REQ-013 IDLE: if req != 0 at edge k, the winner's gnt bit SHALL be high after edge k (1-cycle latency) and the state SHALL become BUSY; if req = 0, it SHALL remain IDLE with gnt = 0.
REQ-014 BUSY: while req[gnt_id] = 1 and the hold limit is not reached, gnt SHALL stay unchanged regardless of other requests.
REQ-015 BUSY with req[gnt_id] = 0: arbitrate among current req in the same cycle; the new winner is granted after the edge (no idle gap); if req = 0, go to IDLE with gnt = 0.
REQ-016 MODE 0: winner = lowest set index of req.
REQ-017 MODE 1: winner = first set bit searching from last_id+1 upward, wrapping from N_REQ-1 to 0; last_id updates to the winner's index on every new grant.
REQ-018 MODE 1: a sole requester equal to last_id SHALL be re-granted (wrap-around to itself).
REQ-019 hold_cnt SHALL clear on each new grant and increment each BUSY cycle the grant is retained, saturating at HOLD_MAX.
REQ-020 HOLD_MAX > 0 and hold_cnt = HOLD_MAX-1 and any other req bit set: the next edge SHALL revoke the grant, grant the next winner excluding the current holder, and pulse preempt for that cycle.
REQ-021 No other requester pending at the hold limit: the grant SHALL be retained and preempt SHALL stay low.
REQ-022 A request deasserted and reasserted by a non-granted master SHALL have no effect on the current grant.

Reset
REQ-023 With rst low, state SHALL be IDLE, gnt = 0, gnt_id = 0, gnt_valid = 0, preempt = 0, hold_cnt = 0 and last_id = N_REQ-1, asynchronously.
REQ-024 Reset asserted mid-grant SHALL drop gnt immediately, without waiting for a clock edge.
REQ-025 The first edge after rst rises SHALL arbitrate as from IDLE; in MODE 1 index 0 has first priority.

Structure
REQ-026 Package wb_interconnect_arb_pkg SHALL hold the FSM state enum and the MODE_FIXED/MODE_RR constants.
REQ-027 Sub-module wb_interconnect_arb_sel SHALL be the combinational rotating-priority picker: inputs req, exclusion mask and start index; outputs winner index and found.
REQ-028 The top module SHALL hold the FSM, hold_cnt and last_id registers and the output registers.

Verification (N_REQ = 4 unless noted)
REQ-029 MODE 1, req = 4'b1111 held, each holder drops its req for 1 cycle after 2 cycles -> grant order 0,1,2,3,0 with no idle gap.
REQ-030 MODE 0, req = 4'b1010, then bit 1 released -> gnt = 4'b0010, then 4'b1000 on the edge after release.
REQ-031 HOLD_MAX = 3, req = 4'b0011 held -> gnt 0001 for 3 cycles, then gnt 0010 with preempt = 1 for exactly one cycle.
REQ-032 HOLD_MAX = 3, req = 4'b0001 held for 10 cycles -> gnt = 0001 throughout and preempt is never high.
REQ-033 Reset pulse while gnt = 4'b0100 -> gnt = 0 with no clock edge; after release, req = 4'b0110 -> gnt = 4'b0010.
REQ-034 Random req for 10k cycles, all modes -> gnt one-hot-or-zero; gnt_valid and gnt_id consistent; no requester waits more than N_REQ grants in MODE 1.
